// File: rtl/init_rom.sv
// ILI9341 init/pixel lookup: maps a sequence index to {dc, byte} plus a post-delay, registered.
// Define LCD_ROM_FAST_SIM_EN for short delays and a 32x24 frame in simulation.
module init_rom #(
  parameter int INIT_LIST_LENGTH = 46,
`ifdef LCD_ROM_FAST_SIM_EN
  parameter int DATA_LIST_LENGTH = 46 + 32*24*2,
`else
  parameter int DATA_LIST_LENGTH = 46 + 320*240*2,
`endif
  parameter int MAX_DELAY_COUNT  = 10000000,
  parameter int DELAY_LONG       = 2400000,
  localparam int ADDR_W  = $clog2(DATA_LIST_LENGTH),
  localparam int DELAY_W = $clog2(MAX_DELAY_COUNT)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  addr,
  input  logic [15:0]        color,
  output logic [8:0]         data,
  output logic [DELAY_W-1:0] delay
);

  localparam logic [ADDR_W-1:0] INIT_END = ADDR_W'(INIT_LIST_LENGTH);
  localparam logic [ADDR_W-1:0] DATA_END = ADDR_W'(DATA_LIST_LENGTH);
  localparam logic [ADDR_W-1:0] SLPOUT_A = ADDR_W'(33);
`ifdef LCD_ROM_FAST_SIM_EN
  localparam logic [DELAY_W-1:0] LONG_D = DELAY_W'(16);
`else
  localparam logic [DELAY_W-1:0] LONG_D = DELAY_W'(DELAY_LONG);
`endif

  // Controller init list: bit 8 is dc (0 = command, 1 = parameter).
  function automatic logic [8:0] init_word(input logic [5:0] i);
    case (i)
      6'd0:  init_word = 9'h001;
      6'd1:  init_word = 9'h028;
      6'd2:  init_word = 9'h0CF;
      6'd3:  init_word = 9'h100;
      6'd4:  init_word = 9'h1C1;
      6'd5:  init_word = 9'h130;
      6'd6:  init_word = 9'h0CB;
      6'd7:  init_word = 9'h139;
      6'd8:  init_word = 9'h12C;
      6'd9:  init_word = 9'h100;
      6'd10: init_word = 9'h134;
      6'd11: init_word = 9'h102;
      6'd12: init_word = 9'h0F7;
      6'd13: init_word = 9'h120;
      6'd14: init_word = 9'h0EA;
      6'd15: init_word = 9'h100;
      6'd16: init_word = 9'h100;
      6'd17: init_word = 9'h0C0;
      6'd18: init_word = 9'h123;
      6'd19: init_word = 9'h0C1;
      6'd20: init_word = 9'h110;
      6'd21: init_word = 9'h0C5;
      6'd22: init_word = 9'h13E;
      6'd23: init_word = 9'h128;
      6'd24: init_word = 9'h0C7;
      6'd25: init_word = 9'h186;
      6'd26: init_word = 9'h036;
      6'd27: init_word = 9'h148;
      6'd28: init_word = 9'h03A;
      6'd29: init_word = 9'h155;
      6'd30: init_word = 9'h0B1;
      6'd31: init_word = 9'h100;
      6'd32: init_word = 9'h118;
      6'd33: init_word = 9'h011;
      6'd34: init_word = 9'h029;
      6'd35: init_word = 9'h02A;
      6'd36: init_word = 9'h100;
      6'd37: init_word = 9'h100;
      6'd38: init_word = 9'h100;
      6'd39: init_word = 9'h1EF;
      6'd40: init_word = 9'h02B;
      6'd41: init_word = 9'h100;
      6'd42: init_word = 9'h100;
      6'd43: init_word = 9'h101;
      6'd44: init_word = 9'h13F;
      6'd45: init_word = 9'h02C;
      default: init_word = 9'h000;
    endcase
  endfunction

  logic [8:0]         nxt_data;
  logic [DELAY_W-1:0] nxt_delay;

  // The init list length is even, so pixel parity is simply addr[0].
  always_comb begin
    nxt_data  = 9'h000;
    nxt_delay = '0;
    if (addr < INIT_END) begin
      nxt_data = init_word(addr[5:0]);
      if (addr == '0 || addr == SLPOUT_A) nxt_delay = LONG_D;
    end else if (addr < DATA_END) begin
      nxt_data = {1'b1, addr[0] ? color[7:0] : color[15:8]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data  <= 9'h000;
      delay <= '0;
    end else begin
      data  <= nxt_data;
      delay <= nxt_delay;
    end
  end

endmodule

// File: tb/tb_init_rom.sv
// Directed bench for init_rom: reset, init table sweep, pixel bytes, colour change, end of stream, random back-to-back.
module tb_init_rom;
`ifdef LCD_ROM_FAST_SIM_EN
  localparam int DLL   = 46 + 32*24*2;
  localparam int LONGV = 16;
`else
  localparam int DLL   = 46 + 320*240*2;
  localparam int LONGV = 2400000;
`endif
  localparam int AW = $clog2(DLL);
  localparam int DW = $clog2(10000000);

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] addr;
  logic [15:0]   color;
  logic [8:0]    data;
  logic [DW-1:0] delay;

  int checks = 0;
  int errors = 0;
  logic [8:0] tbl [46];

  init_rom dut (.clk(clk), .rst(rst), .addr(addr), .color(color), .data(data), .delay(delay));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] exp_data(input int a, input logic [15:0] c);
    if (a < 46) return tbl[a];
    if (a < DLL) return ((a - 46) % 2 == 0) ? {1'b1, c[15:8]} : {1'b1, c[7:0]};
    return 9'h000;
  endfunction

  function automatic logic [31:0] exp_delay(input int a);
    return (a == 0 || a == 33) ? LONGV : 0;
  endfunction

  // Drive at negedge; the output seen at the following negedge belongs to this address.
  task automatic step(input int a, input logic [15:0] c);
    addr  = AW'(a);
    color = c;
    @(negedge clk);
  endtask

  initial begin
    tbl = '{9'h001, 9'h028, 9'h0CF, 9'h100, 9'h1C1, 9'h130, 9'h0CB, 9'h139, 9'h12C, 9'h100,
            9'h134, 9'h102, 9'h0F7, 9'h120, 9'h0EA, 9'h100, 9'h100, 9'h0C0, 9'h123, 9'h0C1,
            9'h110, 9'h0C5, 9'h13E, 9'h128, 9'h0C7, 9'h186, 9'h036, 9'h148, 9'h03A, 9'h155,
            9'h0B1, 9'h100, 9'h118, 9'h011, 9'h029, 9'h02A, 9'h100, 9'h100, 9'h100, 9'h1EF,
            9'h02B, 9'h100, 9'h100, 9'h101, 9'h13F, 9'h02C};
    rst = 1'b1; addr = AW'(5); color = 16'h0000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_data", 32'(data), 32'h000);
      chk("rst_delay", 32'(delay), 0);
    end
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_data", 32'(data), 32'h130);
    chk("post_rst_delay", 32'(delay), 0);

    // init sweep, one address per cycle
    for (int i = 0; i < 46; i++) begin
      step(i, 16'h1234);
      chk($sformatf("init_data[%0d]", i), 32'(data), 32'(tbl[i]));
      chk($sformatf("init_delay[%0d]", i), 32'(delay), exp_delay(i));
    end

    // pixel bytes
    step(46, 16'hF800); chk("pix46", 32'(data), 32'h1F8); chk("pix46_dly", 32'(delay), 0);
    step(47, 16'hF800); chk("pix47", 32'(data), 32'h100);
    step(48, 16'hF800); chk("pix48", 32'(data), 32'h1F8);

    // colour change mid-stream
    step(46, 16'hF800); chk("cc46", 32'(data), 32'h1F8);
    step(47, 16'h07E0); chk("cc47", 32'(data), 32'h1E0);
    step(48, 16'h07E0); chk("cc48", 32'(data), 32'h107);

    // end of stream
    step(DLL - 1, 16'hABCD); chk("last", 32'(data), 32'h1CD); chk("last_dly", 32'(delay), 0);
    step(DLL, 16'hABCD);     chk("past", 32'(data), 32'h000); chk("past_dly", 32'(delay), 0);
    step(45, 16'hABCD);      chk("addr45", 32'(data), 32'h02C);

    // reset mid-sequence clears only the output
    rst = 1'b1; step(33, 16'h5555);
    chk("midrst_data", 32'(data), 32'h000); chk("midrst_dly", 32'(delay), 0);
    rst = 1'b0; step(33, 16'h5555);
    chk("after_midrst", 32'(data), 32'h011); chk("after_midrst_dly", 32'(delay), LONGV);

    // back-to-back random addresses across all regions
    for (int i = 0; i < 60; i++) begin
      int a;
      logic [15:0] c;
      case (i % 3)
        0: a = int'($urandom_range(0, 45));
        1: a = int'($urandom_range(46, DLL - 1));
        default: a = int'($urandom_range(DLL - 4, (1 << AW) - 1));
      endcase
      c = 16'($urandom);
      step(a, c);
      chk($sformatf("rnd_data a=%0d", a), 32'(data), 32'(exp_data(a, c)));
      chk($sformatf("rnd_delay a=%0d", a), 32'(delay), exp_delay(a));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
